mux4_sel_arbiter: RTL
=====================

# mux4_sel_arbiter

Round-robin arbiter that generates the 2-bit select for the 4:1 data mux (`mux4to1`) directly downstream. Four sources raise requests. The arbiter grants one at a time and drives `sel` with the granted index, so the mux forwards that source's data. Each grant is limited to a bounded number of cycles, which keeps any single source from holding the mux.

## Interface

Parameters:
- `HOLD` — default 4 — maximum consecutive cycles a single grant may last; legal range 1..15.

Ports:
- `clk` — in — 1 — single clock; all state updates on the rising edge.
- `rst_n` — in — 1 — reset; one clock, asynchronous, active-low.
- `req` — in — 4 — request per source; bit i maps to mux input d(i+1) (bit0→d1 … bit3→d4).
- `sel` — out — 2 — mux select, registered; equals the index of the granted source.
- `gnt` — out — 4 — one-hot grant, registered; all-zero when idle.
- `busy` — out — 1 — high while any grant is active (equals |gnt).

## Operation

- Two-state FSM: IDLE, GRANT.
- Internal state:
  - `last` (2 bits): index of the most recently granted source.
  - `hold_cnt` (4 bits): cycles spent in the current grant.
- Round-robin search:
  - Scan order starts at `last+1` (mod 4) and wraps, ending at `last`.
  - The first asserted `req` bit in that order wins.
- IDLE:
  - `gnt`=0 and `busy`=0.
  - `sel` holds its previous value, so the mux output is don't-care and no glitch reaches it.
  - If `req`≠0: set `sel`/`gnt` to the round-robin winner, set `last` to the winner, clear `hold_cnt`, go to GRANT.
- GRANT:
  - `hold_cnt` increments each cycle.
  - A release condition holds in a cycle when `req[sel]`=0, or when `hold_cnt`=HOLD-1.
  - With no release condition, the grant is held unchanged.
  - On release, if other requests are pending, re-arbitrate in the same edge, searching from `sel+1`. The winner is granted back-to-back with no idle gap and `hold_cnt` clears to 0.
  - On release with no other request pending:
    - If `req[sel]` is still high (HOLD expiry case), re-grant the same source with `hold_cnt`=0.
    - Otherwise go to IDLE.
- `gnt` is always one-hot or zero, and `gnt[sel]`=1 whenever `busy`=1.
- Counter arithmetic: `hold_cnt` is 4-bit unsigned and never exceeds HOLD-1. For HOLD=1, a release condition holds every cycle.

## Timing

- Reset (asynchronous, `rst_n`=0) sets:
  - `sel`=2'b00, `gnt`=4'b0000, `busy`=0.
  - FSM=IDLE, `hold_cnt`=0, `last`=2'b11, so channel 0 has first priority after reset.
- Reset asserted mid-grant clears the outputs immediately, without waiting for a clock edge. Operation resumes at the first rising edge after `rst_n` deasserts.
- Grant latency:
  - `req` sampled at edge N produces `gnt`/`sel` valid after edge N (visible in cycle N+1).
  - Minimum request-to-grant latency is 1 cycle.
- Release latency:
  - `req[sel]` dropping at edge N means `gnt` changes at edge N.
  - The grant therefore appears one cycle longer than the request at the mux; the downstream side tolerates one trailing cycle.
- Maximum grant length is HOLD cycles. Worst-case wait for a continuously requesting source is 3×HOLD+1 cycles.
- Simultaneous events:
  - New requests arriving during a grant are only considered at release.
  - If `req[sel]` drops and HOLD expires on the same edge, this is a single release; there is no double advance.

## Test plan

- Reset: `rst_n`=0 mid-grant with `req`=4'b1111 → `gnt`=0, `sel`=00 and `busy`=0 immediately. After release, first grant is `gnt`=0001, `sel`=00.
- Single source: `req`=4'b0100 held for 10 cycles, HOLD=4 → `gnt`=0100 and `sel`=10 from the cycle after assertion. Re-granted continuously, with `hold_cnt` wrapping 0..3, and no idle cycle.
- Rotation: `req`=4'b1111 constant, HOLD=4 → `sel` sequence 00,01,10,11,00, each held exactly 4 cycles; `gnt` always one-hot.
- Early release: `req`=4'b0011, source 0 granted, `req[0]` drops after 2 cycles → next edge `sel`=01, `gnt`=0010, `hold_cnt`=0. When `req` becomes 0, return to IDLE: `busy`=0 and `sel` stays 01.
- Wrap priority: `last`=11, `req`=4'b1001 → source 0 wins. Later, with `last`=00 and `req`=4'b1001 → source 3 wins.
- Mux integration: arbiter `sel` drives `mux4to1`, data d1..d4 = 1,0,0,0 then 0,1,0,0 etc. with `req`=1111 → `out` equals d(sel+1) every granted cycle.

Source files
------------

// File: rtl/mux4_sel_arbiter.sv
// -----------------------------------------------------------------------------
// mux4_sel_arbiter
//
// Round-robin arbiter that produces the 2-bit select for the 4:1 data mux
// sitting directly downstream. Four sources raise requests; one is granted at
// a time and its index is driven on sel. A grant lasts at most HOLD cycles,
// after which the next requesting source (in round-robin order) takes over.
//
// Parameters:
//   HOLD          maximum consecutive cycles of one grant (1..15)
//
// Ports:
//   clk           clock, rising edge
//   rst_n         asynchronous active-low reset
//   req[3:0]      request per source (bit i selects mux input d(i+1))
//   sel[1:0]      registered mux select = index of granted source
//   gnt[3:0]      registered one-hot grant, zero when idle
//   busy          high while a grant is active (|gnt)
//   dbg_state     FSM state (0 = IDLE, 1 = GRANT)
//   dbg_hold_cnt  cycles already spent in the current grant
//   dbg_last      index of the most recently granted source
//
// Handshake: there is no valid/ready pair. A source holds req[i] high for as
// long as it wants the mux; it owns the mux in every cycle where gnt[i]=1.
// Dropping req[i] releases the grant at the same edge, so gnt trails req by
// one cycle at the mux.
// -----------------------------------------------------------------------------
module mux4_sel_arbiter #(
    parameter int HOLD = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    output logic [1:0] sel,
    output logic [3:0] gnt,
    output logic       busy,
    output logic       dbg_state,
    output logic [3:0] dbg_hold_cnt,
    output logic [1:0] dbg_last
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Last value hold_cnt may take before the grant has to be released.
    localparam logic [3:0] HOLD_LAST = 4'(HOLD - 1);

    state_t     state_q, state_d;
    logic [1:0] sel_q,   sel_d;
    logic [3:0] gnt_q,   gnt_d;
    logic [1:0] last_q,  last_d;
    logic [3:0] cnt_q,   cnt_d;

    // Round-robin pick: scan indices after+1, after+2, after+3, after and
    // return {found, index} of the first asserted request in that order.
    // The loop runs from lowest to highest priority so that the final
    // overwrite is the winner.
    function automatic logic [2:0] rr_pick(input logic [3:0] r,
                                           input logic [1:0] after);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int k = 4; k >= 1; k--) begin
            idx = after + 2'(k);
            if (r[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    logic [2:0] idle_pick;
    logic [2:0] next_pick;
    logic [3:0] others;
    logic       release_now;

    // From IDLE the search starts after the last granted source; on release
    // it starts after the current owner, who is excluded from the search and
    // only re-granted when nobody else is waiting.
    assign idle_pick   = rr_pick(req, last_q);
    assign others      = req & ~gnt_q;
    assign next_pick   = rr_pick(others, sel_q);
    assign release_now = !req[sel_q] || (cnt_q == HOLD_LAST);

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE: begin
                // sel keeps its old value while idle so the mux sees no change.
                gnt_d = 4'b0000;
                if (idle_pick[2]) begin
                    sel_d   = idle_pick[1:0];
                    gnt_d   = 4'b0001 << idle_pick[1:0];
                    last_d  = idle_pick[1:0];
                    cnt_d   = 4'd0;
                    state_d = GRANT;
                end
            end

            GRANT: begin
                if (!release_now) begin
                    cnt_d = cnt_q + 4'd1;
                end else if (next_pick[2]) begin
                    // Back-to-back handover, no idle cycle in between.
                    sel_d  = next_pick[1:0];
                    gnt_d  = 4'b0001 << next_pick[1:0];
                    last_d = next_pick[1:0];
                    cnt_d  = 4'd0;
                end else if (req[sel_q]) begin
                    // Hold expired but the owner is the only requester.
                    cnt_d = 4'd0;
                end else begin
                    gnt_d   = 4'b0000;
                    cnt_d   = 4'd0;
                    state_d = IDLE;
                end
            end

            default: begin
                gnt_d   = 4'b0000;
                cnt_d   = 4'd0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= 2'b00;
            gnt_q   <= 4'b0000;
            last_q  <= 2'b11;   // source 0 gets first priority after reset
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    assign sel          = sel_q;
    assign gnt          = gnt_q;
    assign busy         = |gnt_q;
    assign dbg_state    = state_q;
    assign dbg_hold_cnt = cnt_q;
    assign dbg_last     = last_q;

endmodule
